// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: steps a[2:0] through the channels set in mask,
// holding en high for DWELL cycles per channel with BLANK cycles of en=0 between channels.
module dec_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] mask,
  output logic [2:0] a,
  output logic       en,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;

  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BL_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_t           st;
  logic [CNT_W-1:0] timer;
  logic [2:0]       nxt_ch, first_ch, idx;
  logic             last_slot;

  // Walk from farthest to nearest so the nearest set bit after a wins; a itself is the fallback.
  always_comb begin
    nxt_ch   = a;
    idx      = '0;
    first_ch = '0;
    for (int k = 7; k >= 1; k--) begin
      idx = a + 3'(k);
      if (mask[idx]) nxt_ch = idx;
    end
    for (int i = 7; i >= 0; i--)
      if (mask[i]) first_ch = 3'(i);
  end

  assign last_slot = (st == S_DWELL && timer == DW_LAST && BLANK == 0) ||
                     (st == S_BLANK && timer == BL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      a          <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      timer      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (stop) begin
        st    <= S_IDLE;
        en    <= 1'b0;
        busy  <= 1'b0;
        timer <= '0;
      end else if (last_slot) begin
        timer <= '0;
        if (mask == 8'h00) begin
          st   <= S_IDLE;
          en   <= 1'b0;
          busy <= 1'b0;
        end else begin
          st         <= S_DWELL;
          a          <= nxt_ch;
          en         <= 1'b1;
          frame_done <= (nxt_ch <= a);
        end
      end else begin
        case (st)
          S_IDLE: begin
            if (start && mask != 8'h00) begin
              st    <= S_DWELL;
              a     <= first_ch;
              en    <= 1'b1;
              busy  <= 1'b1;
              timer <= '0;
            end
          end
          S_DWELL: begin
            if (timer == DW_LAST) begin
              st    <= S_BLANK;
              en    <= 1'b0;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_BLANK: timer <= timer + 1'b1;
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench: two instances (DWELL=4/BLANK=1 and DWELL=1/BLANK=0) share stimulus;
// a slot-position reference model predicts {a,en,busy,frame_done} every cycle.
module tb_dec_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop;
  logic [7:0] mask;
  logic [2:0] a0, a1;
  logic       en0, en1, busy0, busy1, fd0, fd1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DWELL(4), .BLANK(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask),
    .a(a0), .en(en0), .busy(busy0), .frame_done(fd0));

  dec_scan_ctrl #(.DWELL(1), .BLANK(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask),
    .a(a1), .en(en1), .busy(busy1), .frame_done(fd1));

  typedef struct {
    bit act;
    int ch;
    int pos;   // cycle index inside the current channel slot of DWELL+BLANK cycles
    bit fd;
  } mdl_t;

  function automatic int lowest(logic [7:0] mk);
    for (int i = 0; i < 8; i++) if (mk[i]) return i;
    return 0;
  endfunction

  function automatic int next_ch(int c, logic [7:0] mk);
    for (int k = 1; k <= 8; k++) if (mk[(c + k) % 8]) return (c + k) % 8;
    return c;
  endfunction

  function automatic mdl_t step(mdl_t m, int dw, int bl, logic r, logic st, logic sp,
                                logic [7:0] mk);
    mdl_t n;
    int   c;
    n    = m;
    n.fd = 1'b0;
    if (!r) begin
      n = '{act: 1'b0, ch: 0, pos: 0, fd: 1'b0};
    end else if (sp) begin
      n.act = 1'b0;
    end else if (!m.act) begin
      if (st && mk != 8'h00) begin
        n.act = 1'b1;
        n.ch  = lowest(mk);
        n.pos = 0;
      end
    end else begin
      n.pos = m.pos + 1;
      if (n.pos == dw + bl) begin
        n.pos = 0;
        if (mk == 8'h00) n.act = 1'b0;
        else begin
          c     = next_ch(m.ch, mk);
          n.fd  = (c <= m.ch);
          n.ch  = c;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [5:0] outs(mdl_t m, int dw);
    return {3'(m.ch), (m.act && m.pos < dw), m.act, m.fd};
  endfunction

  task automatic chk(string nm, logic [5:0] got, logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got {a,en,busy,fd}=%b required=%b", nm, $time, got, exp);
    end
  endtask

  // Model side: advance on each edge and push the predicted outputs.
  mdl_t m0 = '{act: 1'b0, ch: 0, pos: 0, fd: 1'b0};
  mdl_t m1 = '{act: 1'b0, ch: 0, pos: 0, fd: 1'b0};
  logic [5:0] q0[$], q1[$];

  always @(posedge clk) begin
    m0 = step(m0, 4, 1, rst_n, start, stop, mask);
    m1 = step(m1, 1, 0, rst_n, start, stop, mask);
    q0.push_back(outs(m0, 4));
    q1.push_back(outs(m1, 1));
  end

  // Monitor side: compare away from the active edge.
  logic [2:0] prev_a0 = '0;
  logic       prev_en0 = 1'b0;
  always @(negedge clk) begin
    if (q0.size() > 0) chk("dut0_scan", {a0, en0, busy0, fd0}, q0.pop_front());
    if (q1.size() > 0) chk("dut1_scan", {a1, en1, busy1, fd1}, q1.pop_front());
    if (prev_en0 && en0 && rst_n) chk("dut0_a_stable_under_en", {a0, 3'b0}, {prev_a0, 3'b0});
    prev_a0  = a0;
    prev_en0 = en0;
  end

  task automatic tick(input logic s, input logic p);
    @(negedge clk);
    #1;
    start = s;
    stop  = p;
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mask = 8'h00;
    run(3);
    rst_n = 1'b1;
    run(2);
    // all channels
    mask = 8'hFF; tick(1'b1, 1'b0); run(85);
    // sparse mask, with start pulses landing mid-scan
    tick(1'b0, 1'b1); mask = 8'b1010_0100; tick(1'b1, 1'b0); run(8);
    tick(1'b1, 1'b0); run(3); tick(1'b1, 1'b0); run(30);
    // single channel
    tick(1'b0, 1'b1); mask = 8'h10; tick(1'b1, 1'b0); run(22);
    // mask cleared during channel 3, then a start with empty mask
    tick(1'b0, 1'b1); mask = 8'hFF; tick(1'b1, 1'b0); run(16);
    mask = 8'h00; run(10); tick(1'b1, 1'b0); run(5);
    // stop and start together mid-dwell
    mask = 8'h0F; tick(1'b1, 1'b0); run(2); tick(1'b1, 1'b1); run(4);
    // async reset between edges mid-dwell
    tick(1'b1, 1'b0); run(2);
    @(negedge clk); #2;
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("async_reset_dut0", {a0, en0, busy0, fd0}, 6'b0);
    chk("async_reset_dut1", {a1, en1, busy1, fd1}, 6'b0);
    run(2); rst_n = 1'b1; run(6);
    // two-channel alternation
    mask = 8'h03; tick(1'b1, 1'b0); run(20);
    // randomized traffic, including mask changes and occasional resets
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(19) == 0, $urandom_range(59) == 0);
      if ($urandom_range(14) == 0) mask = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      rst_n = ($urandom_range(249) != 0);
    end
    rst_n = 1'b1;
    run(3);
    @(negedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
